reg_file: RTL and testbench

- 32-entry x 32-bit general-purpose register file for the single-cycle CPU.
- Provides two combinational read ports that feed the ALU operand path and the ALU-source / store-data 32-bit 2:1 muxes.
- Provides one synchronous write port whose data arrives from the MemtoReg 32-bit 2:1 mux and whose address arrives from the RegDst select.
- Register 0 is hardwired to zero; a debug read port exposes any register to the board display logic.

---
 rtl/reg_file_if.sv | 29 ++
 rtl/reg_file.sv | 47 ++++
 tb/tb_reg_file.sv | 125 ++++++++++++
 3 files changed

// File: rtl/reg_file_if.sv
// reg_file_if: register file bus grouping the read, write and debug ports.
// Ports (signals):
//   reg_write, write_reg, write_data: write port driven by the CPU.
//   read_reg1/2 -> read_data1/2: combinational operand read ports.
//   dbg_reg -> dbg_data: debug read port for the board display.
//   write_count: committed writes to non-zero registers since reset.
interface reg_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              reg_write;
    logic [ADDR_W-1:0] read_reg1;
    logic [ADDR_W-1:0] read_reg2;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic [ADDR_W-1:0] dbg_reg;
    logic [DATA_W-1:0] dbg_data;
    logic [15:0]       write_count;
    modport master (
        output reg_write, read_reg1, read_reg2, write_reg, write_data, dbg_reg,
        input  read_data1, read_data2, dbg_data, write_count
    );
    modport slave (
        input  reg_write, read_reg1, read_reg2, write_reg, write_data, dbg_reg,
        output read_data1, read_data2, dbg_data, write_count
    );
endinterface

// File: rtl/reg_file.sv
// reg_file: 2**ADDR_W x DATA_W register file, r0 hardwired to zero.
// Ports:
//   clk: rising-edge clock.
//   rst: synchronous active-high reset; clears storage and write_count.
//   bus: reg_file_if slave; one synchronous write port, two combinational
//        read ports, one combinational debug read port, write counter.
module reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 0
) (
    input logic      clk,
    input logic      rst,
    reg_file_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [15:0]       write_count_q;
    logic [15:0]       write_count_d;
    logic              wr_en;
    // Entry 0 is never written, so it stays at its reset value of zero.
    function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] addr);
        return (addr == '0) ? '0 :
               (BYPASS != 0 && wr_en && addr == bus.write_reg) ? bus.write_data :
               regs_q[addr];
    endfunction
    always_comb begin
        wr_en = bus.reg_write && (bus.write_reg != '0);
        regs_d = regs_q;
        if (wr_en) regs_d[bus.write_reg] = bus.write_data;
        write_count_d = write_count_q + 16'(wr_en);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q        <= '{default: '0};
            write_count_q <= '0;
        end else begin
            regs_q        <= regs_d;
            write_count_q <= write_count_d;
        end
    end
    assign bus.read_data1  = rd(bus.read_reg1);
    assign bus.read_data2  = rd(bus.read_reg2);
    assign bus.dbg_data    = rd(bus.dbg_reg);
    assign bus.write_count = write_count_q;
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed self-checking bench for reg_file, BYPASS=0 and BYPASS=1.
module tb_reg_file;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int failures = 0;
    reg_file_if #(.DATA_W(32), .ADDR_W(5)) ia ();
    reg_file_if #(.DATA_W(32), .ADDR_W(5)) ib ();
    assign ib.reg_write  = ia.reg_write;
    assign ib.read_reg1  = ia.read_reg1;
    assign ib.read_reg2  = ia.read_reg2;
    assign ib.write_reg  = ia.write_reg;
    assign ib.write_data = ia.write_data;
    assign ib.dbg_reg    = ia.dbg_reg;
    reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_a (.clk(clk), .rst(rst), .bus(ia));
    reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut_b (.clk(clk), .rst(rst), .bus(ib));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        ia.reg_write = 1'b1;
        ia.write_reg = a;
        ia.write_data = d;
        tick();
        ia.reg_write = 1'b0;
    endtask
    task automatic rd_all(input logic [4:0] a, input logic [31:0] ea, input logic [31:0] eb, input string tag);
        ia.read_reg1 = a;
        ia.read_reg2 = a;
        ia.dbg_reg = a;
        #1;
        check({tag, " a.rd1"}, ia.read_data1, ea);
        check({tag, " a.rd2"}, ia.read_data2, ea);
        check({tag, " a.dbg"}, ia.dbg_data, ea);
        check({tag, " b.rd1"}, ib.read_data1, eb);
        check({tag, " b.rd2"}, ib.read_data2, eb);
        check({tag, " b.dbg"}, ib.dbg_data, eb);
    endtask
    initial begin
        rst = 1'b1;
        ia.reg_write = 1'b1;
        ia.write_reg = 5'd5;
        ia.write_data = 32'hDEADBEEF;
        ia.read_reg1 = '0;
        ia.read_reg2 = '0;
        ia.dbg_reg = '0;
        tick();
        tick();
        rst = 1'b0;
        ia.reg_write = 1'b0;
        check("reset count a", 32'(ia.write_count), 32'd0);
        check("reset count b", 32'(ib.write_count), 32'd0);
        for (int i = 0; i < 32; i++) rd_all(5'(i), 32'd0, 32'd0, "reset");
        wr(5'd8, 32'h12345678);
        wr(5'd31, 32'hCAFEF00D);
        ia.read_reg1 = 5'd8;
        ia.read_reg2 = 5'd31;
        #1;
        check("basic rd1", ia.read_data1, 32'h12345678);
        check("basic rd2", ia.read_data2, 32'hCAFEF00D);
        check("basic count", 32'(ia.write_count), 32'd2);
        ia.reg_write = 1'b1;
        ia.write_reg = 5'd0;
        ia.write_data = 32'hFFFFFFFF;
        rd_all(5'd0, 32'd0, 32'd0, "r0 pre");
        tick();
        ia.reg_write = 1'b0;
        rd_all(5'd0, 32'd0, 32'd0, "r0 post");
        check("r0 count", 32'(ia.write_count), 32'd2);
        wr(5'd9, 32'h00000001);
        ia.reg_write = 1'b1;
        ia.write_reg = 5'd9;
        ia.write_data = 32'h00000002;
        rd_all(5'd9, 32'h1, 32'h2, "hazard pre");
        tick();
        ia.reg_write = 1'b0;
        rd_all(5'd9, 32'h2, 32'h2, "hazard post");
        check("hazard count", 32'(ia.write_count), 32'd4);
        ia.write_reg = 5'd3;
        ia.write_data = 32'hAAAA5555;
        tick();
        rd_all(5'd3, 32'd0, 32'd0, "gated");
        check("gated count", 32'(ia.write_count), 32'd4);
        wr(5'd3, 32'h00000077);
        rd_all(5'd3, 32'h77, 32'h77, "r3 set");
        rst = 1'b1;
        ia.reg_write = 1'b1;
        ia.write_reg = 5'd3;
        ia.write_data = 32'h00000088;
        tick();
        rst = 1'b0;
        ia.reg_write = 1'b0;
        rd_all(5'd3, 32'd0, 32'd0, "rst prio r3");
        rd_all(5'd8, 32'd0, 32'd0, "rst prio r8");
        check("rst prio count", 32'(ia.write_count), 32'd0);
        wr(5'd4, 32'h00000044);
        rd_all(5'd4, 32'h44, 32'h44, "resume");
        check("resume count", 32'(ia.write_count), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ia.reg_write = 1'b1;
        ia.write_reg = 5'd1;
        for (int i = 0; i < 65536; i++) begin
            ia.write_data = 32'hA5000000 | 32'(i);
            tick();
            if (i == 65534) check("wrap ffff", 32'(ia.write_count), 32'h0000FFFF);
        end
        ia.reg_write = 1'b0;
        check("wrap zero a", 32'(ia.write_count), 32'd0);
        check("wrap zero b", 32'(ib.write_count), 32'd0);
        rd_all(5'd1, 32'hA500FFFF, 32'hA500FFFF, "wrap r1");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
